// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from a show-ahead FIFO and serialises them LSB first.
// Contains its own baud divider; one idle cycle separates consecutive frames.
module uart_tx_fifo_drain #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W    = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

   if (BAUD_DIV < 2) begin : g_bad_baud_div
      $error("uart_tx_fifo_drain: CLK_FREQ/BAUD must be at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             busy_q;
   logic             done_q;
   logic             bit_end;

   assign bit_end  = (cnt_q == CNT_LAST);
   // Gated by reset so a byte is never consumed while the transmitter is held in reset.
   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty && !reset;

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q  <= bit_end ? '0 : cnt_q + CNT_W'(1);
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               tx_q  <= 1'b1;
               if (fifo_pop) begin
                  shift_q <= fifo_data;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state_q <= S_DATA;
                  idx_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                     tx_q  <= shift_q[idx_q + 3'd1];
                  end
               end
            end
            S_STOP: begin
               // Registered pulse lands on the final cycle of the stop bit.
               done_q <= (cnt_q == CNT_PRE);
               if (bit_end) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: two instances (10 and 2 clocks per bit) each fed by a queue FIFO,
// with expected line levels derived from the 8N1 frame definition.
module tb_uart_tx_fifo_drain;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       empty_a = 1'b1;
   logic [7:0] data_a  = 8'h00;
   logic       pop_a, tx_a, busy_a, done_a;
   logic       empty_b = 1'b1;
   logic [7:0] data_b  = 8'h00;
   logic       pop_b, tx_b, busy_b, done_b;

   uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100)) dut_a (
      .clk(clk), .reset(reset), .fifo_empty(empty_a), .fifo_data(data_a),
      .fifo_pop(pop_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

   uart_tx_fifo_drain #(.CLK_FREQ(200), .BAUD(100)) dut_b (
      .clk(clk), .reset(reset), .fifo_empty(empty_b), .fifo_data(data_b),
      .fifo_pop(pop_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

   int n_cmp  = 0;
   int n_fail = 0;
   byte unsigned qa[$];
   byte unsigned qb[$];
   int pops_a = 0;
   int pops_b = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Queue FIFO models: pop on the strobe, present the new head after the edge.
   always @(posedge clk) begin
      if (pop_a) begin
         chk1("pop_a_while_busy", busy_a, 1'b0);
         chk1("pop_a_while_empty", empty_a, 1'b0);
         if (qa.size() > 0) qa.delete(0);
         pops_a++;
      end
      empty_a <= (qa.size() == 0);
      data_a  <= (qa.size() > 0) ? qa[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (pop_b) begin
         chk1("pop_b_while_busy", busy_b, 1'b0);
         chk1("pop_b_while_empty", empty_b, 1'b0);
         if (qb.size() > 0) qb.delete(0);
         pops_b++;
      end
      empty_b <= (qb.size() == 0);
      data_b  <= (qb.size() > 0) ? qb[0] : 8'h00;
   end

   function automatic int divof(input int u);
      return (u == 0) ? 10 : 2;
   endfunction
   function automatic logic get_tx(input int u);
      return (u == 0) ? tx_a : tx_b;
   endfunction
   function automatic logic get_busy(input int u);
      return (u == 0) ? busy_a : busy_b;
   endfunction
   function automatic logic get_done(input int u);
      return (u == 0) ? done_a : done_b;
   endfunction
   function automatic logic get_pop(input int u);
      return (u == 0) ? pop_a : pop_b;
   endfunction

   // Line level k clocks into a frame: slot 0 start, slots 1..8 data LSB first, slot 9 stop.
   function automatic logic exp_level(input byte unsigned b, input int k, input int div);
      int slot;
      slot = k / div;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   task automatic push(input int u, input byte unsigned b);
      if (u == 0) qa.push_back(b);
      else        qb.push_back(b);
   endtask

   task automatic wait_pop(input int u, output int waited);
      bit found;
      found  = 1'b0;
      waited = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (get_pop(u)) begin
            found = 1'b1;
            chk1("idle_tx_at_pop", get_tx(u), 1'b1);
            chk1("idle_busy_at_pop", get_busy(u), 1'b0);
         end else begin
            waited++;
         end
      end
      if (!found) chkn("pop_timeout", 0, 1);
   endtask

   task automatic check_frame(input int u, input byte unsigned b, input int push_at,
                              input byte unsigned push_val);
      int div;
      div = divof(u);
      for (int k = 0; k < 10 * div; k++) begin
         @(negedge clk);
         chk1($sformatf("tx_%02h_k%0d", b, k), get_tx(u), exp_level(b, k, div));
         chk1($sformatf("busy_%02h_k%0d", b, k), get_busy(u), 1'b1);
         chk1($sformatf("done_%02h_k%0d", b, k), get_done(u), (k == 10 * div - 1));
         chk1($sformatf("pop_in_frame_%02h", b), get_pop(u), 1'b0);
         if (k == push_at) push(u, push_val);
      end
   endtask

   initial begin
      int w;
      int p;
      int n;
      byte unsigned rb[$];

      repeat (3) @(negedge clk);
      chk1("rst_tx_a", tx_a, 1'b1);
      chk1("rst_busy_a", busy_a, 1'b0);
      chk1("rst_done_a", done_a, 1'b0);
      chk1("rst_pop_a", pop_a, 1'b0);
      chk1("rst_tx_b", tx_b, 1'b1);
      chk1("rst_busy_b", busy_b, 1'b0);
      reset = 1'b0;

      // Empty FIFO: line stays idle.
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         chk1("empty_tx", tx_a, 1'b1);
         chk1("empty_pop", pop_a, 1'b0);
         chk1("empty_busy", busy_a, 1'b0);
      end

      // Single byte.
      p = pops_a;
      push(0, 8'hA5);
      wait_pop(0, w);
      check_frame(0, 8'hA5, -1, 8'h00);
      @(negedge clk);
      chk1("a5_after_tx", tx_a, 1'b1);
      chk1("a5_after_busy", busy_a, 1'b0);
      chk1("a5_after_done", done_a, 1'b0);
      chkn("a5_pop_count", pops_a - p, 1);

      // Back-to-back frames with a one-clock gap.
      p = pops_a;
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h55);
      wait_pop(0, w);
      check_frame(0, 8'h00, -1, 8'h00);
      wait_pop(0, w);
      chkn("b2b_gap_1", w, 0);
      check_frame(0, 8'hFF, -1, 8'h00);
      wait_pop(0, w);
      chkn("b2b_gap_2", w, 0);
      check_frame(0, 8'h55, -1, 8'h00);
      chkn("b2b_pop_count", pops_a - p, 3);

      // Push while a frame is in its data bits.
      push(0, 8'hA1);
      wait_pop(0, w);
      check_frame(0, 8'hA1, 53, 8'h3C);
      wait_pop(0, w);
      chkn("push_mid_gap", w, 0);
      check_frame(0, 8'h3C, -1, 8'h00);

      // Reset during data bit 3; the aborted byte is not re-sent.
      p = pops_a;
      push(0, 8'h81);
      wait_pop(0, w);
      repeat (44) @(negedge clk);
      chk1("pre_rst_bit3", tx_a, exp_level(8'h81, 43, 10));
      #2 reset = 1'b1;
      #1;
      chk1("midrst_tx", tx_a, 1'b1);
      chk1("midrst_busy", busy_a, 1'b0);
      chk1("midrst_done", done_a, 1'b0);
      push(0, 8'h42);
      repeat (3) begin
         @(negedge clk);
         chk1("midrst_no_pop", pop_a, 1'b0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      wait_pop(0, w);
      chkn("post_rst_wait", w, 0);
      check_frame(0, 8'h42, -1, 8'h00);
      chkn("rst_pop_count", pops_a - p, 2);
      chkn("rst_queue_empty", qa.size(), 0);

      // Random bursts.
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         n = $urandom_range(1, 3);
         rb.delete();
         for (int i = 0; i < n; i++) begin
            rb.push_back(8'($urandom));
            push(0, rb[i]);
         end
         for (int i = 0; i < n; i++) begin
            wait_pop(0, w);
            if (i > 0) chkn("rand_gap", w, 0);
            check_frame(0, rb[i], -1, 8'h00);
         end
      end

      // Two clocks per bit.
      p = pops_b;
      push(1, 8'hC3);
      wait_pop(1, w);
      check_frame(1, 8'hC3, -1, 8'h00);
      for (int i = 0; i < 2; i++) begin
         rb.delete();
         rb.push_back(8'($urandom));
         push(1, rb[0]);
         wait_pop(1, w);
         check_frame(1, rb[0], -1, 8'h00);
      end
      chkn("div2_pop_count", pops_b - p, 3);
      @(negedge clk);
      chk1("div2_idle_tx", tx_b, 1'b1);
      chk1("div2_idle_busy", busy_b, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
